nic_slave_regs: RTL and testbench

NIC_SLAVE_REGS -- requirements
Module: nic_slave_regs

---
 rtl/nic_slave_regs.sv | 160 ++++++++++++++++
 tb/tb_nic_slave_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : nic_slave_regs
// Brief    : Interconnect slave register file with byte-enabled writes,
//            configurable wait states and a single-cycle registered ack.
//            Optional macro NIC_SLAVE_ERR_EN adds an o_err output flagging
//            acks of out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module nic_slave_regs #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int REGS_COUNT  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_sel,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic                      i_wr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_ack
`ifdef NIC_SLAVE_ERR_EN
    ,
    output logic                      o_err
`endif
);

    localparam int                  c_bytes      = DATA_WIDTH / 8;
    // One extra bit so REGS_COUNT == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] c_regs_limit = (ADDR_WIDTH + 1)'(REGS_COUNT);
    localparam logic [3:0]          c_wait_load  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_enter_ack;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_regs [REGS_COUNT];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ack;

    // Full-width compare, so addresses beyond the file never alias onto it.
    assign w_in_range  = ({1'b0, i_addr} < c_regs_limit);
    // Request fields are sampled on the edge that moves the FSM into ACK.
    assign w_enter_ack = (w_state_next == ACK);

    // State and wait counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: optional wait phase, abort on deselect, one-cycle ack.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_sel) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_wait_load;
                    end else begin
                        w_state_next = ACK;
                    end
                end
            end
            WAIT: begin
                if (!i_sel) begin
                    w_state_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Read mux; unmatched (out-of-range) addresses read as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < REGS_COUNT; i++) begin
            if (i_addr == ADDR_WIDTH'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Register file: byte-enabled write on the edge entering ACK.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < REGS_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_enter_ack && i_wr && w_in_range) begin
            for (int i = 0; i < REGS_COUNT; i++) begin
                for (int b = 0; b < c_bytes; b++) begin
                    if ((i_addr == ADDR_WIDTH'(i)) && i_wstrb[b]) begin
                        r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered ack and read data; read data is zero outside read acks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_enter_ack;
            r_rdata <= (w_enter_ack && !i_wr) ? w_rd_word : '0;
        end
    end

    assign o_ack   = r_ack;
    assign o_rdata = r_rdata;

`ifdef NIC_SLAVE_ERR_EN
    logic r_err;

    // Error flag accompanies the ack of an out-of-range access.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_ack && !w_in_range;
        end
    end

    assign o_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nic_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic_slave_regs
// Brief    : Self-checking bench for nic_slave_regs; two instances (0 and 3
//            wait states) checked against a register-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic_slave_regs;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        sel0, sel3;
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata0, rdata3;
    logic        ack0, ack3;
`ifdef NIC_SLAVE_ERR_EN
    logic        err0, err3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model0 [8];
    logic [31:0] model3 [8];

    always #5 clk = ~clk;

    nic_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .REGS_COUNT(8), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst0), .i_sel(sel0), .i_addr(addr), .i_wr(wr),
        .i_wdata(wdata), .i_wstrb(wstrb), .o_rdata(rdata0), .o_ack(ack0)
`ifdef NIC_SLAVE_ERR_EN
        , .o_err(err0)
`endif
    );

    nic_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .REGS_COUNT(8), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_reset(rst3), .i_sel(sel3), .i_addr(addr), .i_wr(wr),
        .i_wdata(wdata), .i_wstrb(wstrb), .o_rdata(rdata3), .o_ack(ack3)
`ifdef NIC_SLAVE_ERR_EN
        , .o_err(err3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic ack_of(input int which);
        return (which == 0) ? ack0 : ack3;
    endfunction

    function automatic logic [31:0] rdata_of(input int which);
        return (which == 0) ? rdata0 : rdata3;
    endfunction

`ifdef NIC_SLAVE_ERR_EN
    function automatic logic err_of(input int which);
        return (which == 0) ? err0 : err3;
    endfunction
`endif

    task automatic set_sel(input int which, input logic v);
        if (which == 0) sel0 = v;
        else            sel3 = v;
    endtask

    // One complete access: checks latency, single-cycle ack, read data and model.
    task automatic xact(input int which, input logic [3:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd_out);
        int          lat;
        int          ws;
        logic        idle_ok;
        logic [31:0] rd;
        logic [31:0] exp;
        logic        in_range;
`ifdef NIC_SLAVE_ERR_EN
        logic        er;
        er = 1'b0;
`endif
        ws       = (which == 0) ? 0 : 3;
        in_range = (a < 4'd8);
        rd       = '0;
        lat      = 0;
        idle_ok  = 1'b1;
        @(negedge clk);
        addr = a; wr = w; wdata = d; wstrb = s;
        set_sel(which, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack_of(which)) begin
                lat = k;
                rd  = rdata_of(which);
`ifdef NIC_SLAVE_ERR_EN
                er  = err_of(which);
`endif
                break;
            end
            if (rdata_of(which) !== 32'd0) idle_ok = 1'b0;
        end
        set_sel(which, 1'b0);
        chk("ack_latency", 32'(lat), 32'(1 + ws));
        chk("rdata_zero_before_ack", 32'(idle_ok), 32'd1);
        if (w) begin
            exp = 32'd0;
            if (in_range) begin
                if (which == 0) model0[a[2:0]] = merge(model0[a[2:0]], d, s);
                else            model3[a[2:0]] = merge(model3[a[2:0]], d, s);
            end
        end else begin
            exp = !in_range ? 32'd0 : (which == 0) ? model0[a[2:0]] : model3[a[2:0]];
        end
        chk(w ? "write_ack_rdata" : "read_rdata", rd, exp);
`ifdef NIC_SLAVE_ERR_EN
        chk("err_on_ack", 32'(er), 32'(!in_range));
`endif
        @(posedge clk); #1;
        chk("ack_single_cycle", 32'(ack_of(which)), 32'd0);
        chk("rdata_zero_after_ack", rdata_of(which), 32'd0);
        rd_out = rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic        ok;
        rst0 = 1'b1; rst3 = 1'b1; sel0 = 1'b0; sel3 = 1'b0;
        addr = '0; wr = 1'b0; wdata = '0; wstrb = '0;
        for (int i = 0; i < 8; i++) begin model0[i] = '0; model3[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack0", 32'(ack0), 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_ack3", 32'(ack3), 32'd0);
        chk("reset_rdata3", rdata3, 32'd0);
`ifdef NIC_SLAVE_ERR_EN
        chk("reset_err0", 32'(err0), 32'd0);
`endif
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;

        // Write then read back, zero wait states
        xact(0, 4'd2, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        xact(0, 4'd2, 1'b0, 32'h0, 4'h0, rd);
        chk("readback_deadbeef", rd, 32'hDEADBEEF);

        // Partial byte strobes
        xact(0, 4'd3, 1'b1, 32'h11223344, 4'hF, rd);
        xact(0, 4'd3, 1'b1, 32'hAABBCCDD, 4'h5, rd);
        xact(0, 4'd3, 1'b0, 32'h0, 4'h0, rd);
        chk("strobe_merge", rd, 32'h11BB33DD);

        // Out-of-range access, and no aliasing onto register 1
        xact(0, 4'd9, 1'b1, 32'h5, 4'hF, rd);
        xact(0, 4'd9, 1'b0, 32'h0, 4'h0, rd);
        chk("oor_read_zero", rd, 32'd0);
        xact(0, 4'd1, 1'b0, 32'h0, 4'h0, rd);
        chk("no_alias_reg1", rd, 32'd0);

        // Back-to-back reads with select held
        xact(0, 4'd0, 1'b1, 32'h1, 4'hF, rd);
        xact(0, 4'd1, 1'b1, 32'h2, 4'hF, rd);
        @(negedge clk);
        addr = 4'd0; wr = 1'b0; sel0 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ack_c1", 32'(ack0), 32'd1);
        chk("b2b_rdata_c1", rdata0, 32'h1);
        addr = 4'd1;
        @(posedge clk); #1;
        chk("b2b_ack_c2", 32'(ack0), 32'd0);
        chk("b2b_rdata_c2", rdata0, 32'd0);
        @(posedge clk); #1;
        chk("b2b_ack_c3", 32'(ack0), 32'd1);
        chk("b2b_rdata_c3", rdata0, 32'h2);
        sel0 = 1'b0;
        @(posedge clk); #1;
        chk("b2b_ack_c4", 32'(ack0), 32'd0);

        // Three wait states: held read acks in cycle 4 only
        xact(3, 4'd2, 1'b1, 32'hCAFE0001, 4'hF, rd);
        xact(3, 4'd2, 1'b0, 32'h0, 4'h0, rd);
        chk("ws3_readback", rd, 32'hCAFE0001);

        // Abort in WAIT: no write, FSM back in IDLE by cycle 3
        @(negedge clk);
        addr = 4'd5; wr = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; sel3 = 1'b1;
        @(posedge clk); #1;
        chk("abort_ack_c1", 32'(ack3), 32'd0);
        @(posedge clk); #1;
        sel3 = 1'b0;
        chk("abort_ack_c2", 32'(ack3), 32'd0);
        @(posedge clk); #1;
        chk("abort_ack_c3", 32'(ack3), 32'd0);
        wr = 1'b0; sel3 = 1'b1;
        ok = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (ack3 !== 1'b0) ok = 1'b0;
        end
        chk("abort_new_no_early_ack", 32'(ok), 32'd1);
        @(posedge clk); #1;
        chk("abort_new_ack_c4", 32'(ack3), 32'd1);
        chk("abort_no_write", rdata3, model3[5]);
        sel3 = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack_after", 32'(ack3), 32'd0);

        // Reset during WAIT of a write drops it
        xact(3, 4'd1, 1'b1, 32'h0BADCAFE, 4'hF, rd);
        @(negedge clk);
        addr = 4'd1; wr = 1'b1; wdata = 32'h77777777; wstrb = 4'hF; sel3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0; sel3 = 1'b0;
        for (int i = 0; i < 8; i++) model3[i] = '0;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ack3 !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("reset_drop_no_ack", 32'(ok), 32'd1);
        xact(3, 4'd1, 1'b0, 32'h0, 4'h0, rd);
        chk("reset_drop_reg1_zero", rd, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++)
            xact(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)), rd);
        for (int n = 0; n < 10; n++)
            xact(3, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)), rd);
        for (int i = 0; i < 8; i++) begin
            xact(0, 4'(i), 1'b0, 32'h0, 4'h0, rd);
            xact(3, 4'(i), 1'b0, 32'h0, 4'h0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
